// File: rtl/pdecoder_3to8_seq.sv
// Sequenced 3-to-8 decoder: each accepted index is shown one-hot on D for
// HOLD_CYCLES cycles, then D is forced to zero for GAP_CYCLES cycles.
// Optional sticky per-index "seen" flags are enabled by defining PDECODER_SEEN_EN.
module pdecoder_3to8_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] Y,
    input  logic       y_valid,
    output logic       y_ready,
    output logic [7:0] D,
    output logic       d_active,
    output logic       busy
`ifdef PDECODER_SEEN_EN
    ,
    input  logic       clr_seen,
    output logic [7:0] seen
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Counters hold "cycles remaining minus one" so zero means last cycle.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [7:0] d_q;
    logic       act_q;
    logic [7:0] dec;
    logic       accept;

    assign dec      = 8'd1 << Y;
    assign y_ready  = (state_q == IDLE);
    assign busy     = ~y_ready;
    assign accept   = y_valid & y_ready;
    assign D        = d_q;
    assign d_active = act_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            d_q     <= 8'h00;
            act_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= DRIVE;
                        cnt_q   <= HOLD_LOAD;
                        d_q     <= dec;
                        act_q   <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        d_q   <= 8'h00;
                        act_q <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state_q <= GAP;
                            cnt_q   <= GAP_LOAD;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= 8'd0;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 8'd0;
                    d_q     <= 8'h00;
                    act_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PDECODER_SEEN_EN
    logic [7:0] seen_q;

    // A new acceptance survives a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 8'h00;
        end else begin
            seen_q <= (clr_seen ? 8'h00 : seen_q) | (accept ? dec : 8'h00);
        end
    end

    assign seen = seen_q;
`endif

endmodule

// File: tb/tb_pdecoder_3to8_seq.sv
// Scoreboard bench for pdecoder_3to8_seq: a default instance and a
// HOLD_CYCLES=1 / GAP_CYCLES=0 instance share clock and reset.
module tb_pdecoder_3to8_seq;

    logic       clk;
    logic       rst_n;
    logic [2:0] a_Y, b_Y;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic [7:0] a_D, b_D;
    logic       a_act, b_act;
    logic       a_busy, b_busy;
`ifdef PDECODER_SEEN_EN
    logic       a_clr, b_clr;
    logic [7:0] a_seen, b_seen;
`endif

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp;

    pdecoder_3to8_seq u_a (
        .clk(clk), .rst_n(rst_n), .Y(a_Y), .y_valid(a_valid), .y_ready(a_ready),
        .D(a_D), .d_active(a_act), .busy(a_busy)
`ifdef PDECODER_SEEN_EN
        , .clr_seen(a_clr), .seen(a_seen)
`endif
    );

    pdecoder_3to8_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .Y(b_Y), .y_valid(b_valid), .y_ready(b_ready),
        .D(b_D), .d_active(b_act), .busy(b_busy)
`ifdef PDECODER_SEEN_EN
        , .clr_seen(b_clr), .seen(b_seen)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic wait_ready_a(input string nm);
        int n = 0;
        while (a_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout: y_ready=%b want 1", nm, a_ready);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (a_D !== 8'h00 || a_act !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1 ||
            b_D !== 8'h00 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: D=%h act=%b busy=%b rdy=%b bD=%h brdy=%b want 00 0 0 1 00 1",
                     a_D, a_act, a_busy, a_ready, b_D, b_ready);
        end
`ifdef PDECODER_SEEN_EN
        checks++;
        if (a_seen !== 8'h00) begin
            errors++;
            $display("FAIL reset_seen: seen=%h want 00", a_seen);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        wait_ready_a("single");
        a_Y = 3'd5; a_valid = 1'b1;
        exp_q.push_back(8'h20);
        @(posedge clk); #1;
        a_valid = 1'b0;
        exp = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            checks++;
            if (a_D !== exp || a_act !== 1'b1 || a_busy !== 1'b1 || a_ready !== 1'b0) begin
                errors++;
                $display("FAIL single_drive%0d: D=%h act=%b busy=%b rdy=%b want %h 1 1 0",
                         i, a_D, a_act, a_busy, a_ready, exp);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (a_D !== 8'h00 || a_act !== 1'b0 || a_busy !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_gap: D=%h act=%b busy=%b rdy=%b want 00 0 1 0",
                     a_D, a_act, a_busy, a_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: rdy=%b busy=%b want 1 0", a_ready, a_busy);
        end
    endtask

    task automatic test_ignore_busy();
        wait_ready_a("ignore");
        a_Y = 3'd1; a_valid = 1'b1;
        exp_q.push_back(8'h02);
        @(posedge clk); #1;
        // Source switches to Y=3 and holds it while the block is busy.
        a_Y = 3'd3;
        exp_q.push_back(8'h08);
        exp = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            checks++;
            if (a_D !== exp || a_ready !== 1'b0) begin
                errors++;
                $display("FAIL ignore_drive%0d: D=%h rdy=%b want %h 0", i, a_D, a_ready, exp);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (a_D !== 8'h00 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL ignore_gap: D=%h rdy=%b want 00 0", a_D, a_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_D !== 8'h00 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_idle: D=%h rdy=%b want 00 1", a_D, a_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (a_D !== exp || a_act !== 1'b1) begin
            errors++;
            $display("FAIL ignore_next: D=%h act=%b want %h 1", a_D, a_act, exp);
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        wait_ready_a("rstmid");
        a_Y = 3'd6; a_valid = 1'b1;
        exp_q.push_back(8'h40);
        @(posedge clk); #1;
        a_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (a_D !== exp) begin
            errors++;
            $display("FAIL rstmid_drive: D=%h want %h", a_D, exp);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_D !== 8'h00 || a_act !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: D=%h act=%b busy=%b rdy=%b want 00 0 0 1",
                     a_D, a_act, a_busy, a_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_Y = 3'd2; a_valid = 1'b1;
        exp_q.push_back(8'h04);
        @(posedge clk); #1;
        a_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (a_D !== exp || a_act !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after: D=%h act=%b want %h 1", a_D, a_act, exp);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_min_interval();
        @(negedge clk);
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL minint_ready: rdy=%b want 1", b_ready);
        end
        b_Y = 3'd0; b_valid = 1'b1;
        exp_q.push_back(8'h01);
        @(posedge clk); #1;
        b_Y = 3'd7;
        exp_q.push_back(8'h80);
        exp = exp_q.pop_front();
        checks++;
        if (b_D !== exp || b_act !== 1'b1) begin
            errors++;
            $display("FAIL minint_first: D=%h act=%b want %h 1", b_D, b_act, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (b_D !== 8'h00 || b_act !== 1'b0 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL minint_between: D=%h act=%b rdy=%b want 00 0 1", b_D, b_act, b_ready);
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (b_D !== exp || b_act !== 1'b1) begin
            errors++;
            $display("FAIL minint_second: D=%h act=%b want %h 1", b_D, b_act, exp);
        end
        @(posedge clk); #1;
        checks++;
        if (b_D !== 8'h00 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL minint_end: D=%h rdy=%b want 00 1", b_D, b_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int y = 0; y < 8; y++) begin
            wait_ready_a("sweep");
            a_Y = 3'(y); a_valid = 1'b1;
            exp_q.push_back(8'h01 << y);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            for (int i = 0; i < 4; i++) begin
                if (i > 0) begin @(posedge clk); #1; end
                checks++;
                if (a_D !== exp || !$onehot(a_D) || a_act !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep_y%0d_c%0d: D=%h act=%b want %h 1", y, i, a_D, a_act, exp);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (a_D !== 8'h00 || a_busy !== 1'b1) begin
                errors++;
                $display("FAIL sweep_gap_y%0d: D=%h busy=%b want 00 1", y, a_D, a_busy);
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
    endtask

`ifdef PDECODER_SEEN_EN
    task automatic test_seen();
        wait_ready_a("seen1");
        a_Y = 3'd1; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        wait_ready_a("seen4");
        a_Y = 3'd4; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        checks++;
        if (a_seen !== 8'h12) begin
            errors++;
            $display("FAIL seen_accum: seen=%h want 12", a_seen);
        end
        wait_ready_a("seen7");
        a_Y = 3'd7; a_valid = 1'b1; a_clr = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; a_clr = 1'b0;
        checks++;
        if (a_seen !== 8'h80) begin
            errors++;
            $display("FAIL seen_clr_set: seen=%h want 80", a_seen);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        a_Y = 3'd0; a_valid = 1'b0;
        b_Y = 3'd0; b_valid = 1'b0;
`ifdef PDECODER_SEEN_EN
        a_clr = 1'b0; b_clr = 1'b0;
`endif
        test_reset();
        test_single();
        test_ignore_busy();
        test_reset_mid();
        test_min_interval();
        test_back_to_back();
`ifdef PDECODER_SEEN_EN
        test_seen();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
